// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: EX forwarding, load-use/MDU stalls, branch/jump flushes and MDU sequencing.
// Optional HAZ_PERF_EN adds the Perf_Stall/Perf_Flush cycle counters.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  EX_rs,
    input  logic [4:0]  EX_rt,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteAddr,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteAddr,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteAddr,
    input  logic        EX_BranchTaken,
    input  logic        ID_Jump,
    input  logic        ID_MDStart,
    input  logic        ID_MDDiv,
    input  logic        ID_HiLoRead,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        MD_Start,
    output logic        MD_IsDiv,
    output logic        MD_Busy,
    output logic        MD_Done
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] Perf_Stall,
    output logic [31:0] Perf_Flush
`endif
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          lu, ms, stall;

    // EX/MEM result is younger than MEM/WB, so it wins when both match
    assign ForwardA = (MEM_RegWrite && MEM_WriteAddr != 5'd0 && MEM_WriteAddr == EX_rs) ? 2'b10 :
                      (WB_RegWrite && WB_WriteAddr != 5'd0 && WB_WriteAddr == EX_rs) ? 2'b01 : 2'b00;
    assign ForwardB = (MEM_RegWrite && MEM_WriteAddr != 5'd0 && MEM_WriteAddr == EX_rt) ? 2'b10 :
                      (WB_RegWrite && WB_WriteAddr != 5'd0 && WB_WriteAddr == EX_rt) ? 2'b01 : 2'b00;

    assign lu    = EX_MemRead && EX_WriteAddr != 5'd0 && (EX_WriteAddr == ID_rs || EX_WriteAddr == ID_rt);
    assign ms    = (state == BUSY) && (ID_MDStart || ID_HiLoRead);
    assign stall = lu || ms;

    assign PC_Write   = EX_BranchTaken || !stall;
    assign IFID_Write = EX_BranchTaken || !stall;
    assign IFID_Flush = EX_BranchTaken || (!stall && ID_Jump);
    assign IDEX_Flush = EX_BranchTaken || stall;
    assign MD_Start   = ID_MDStart && !EX_BranchTaken && !stall;
    assign MD_IsDiv   = ID_MDDiv;
    assign MD_Busy    = state == BUSY;
    assign MD_Done    = state == DONE;

    // cnt is loaded with LAT-1 so BUSY spans exactly LAT cycles
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == BUSY) begin
            state_next = (cnt == '0) ? DONE : BUSY;
            cnt_next   = (cnt == '0) ? cnt : cnt - CW'(1);
        end else begin
            state_next = MD_Start ? BUSY : IDLE;
            cnt_next   = MD_Start ? (MD_IsDiv ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1)) : cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Perf_Stall <= '0;
            Perf_Flush <= '0;
        end else begin
            Perf_Stall <= Perf_Stall + 32'(stall && !EX_BranchTaken);
            Perf_Flush <= Perf_Flush + 32'(EX_BranchTaken || ID_Jump);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of pipeline_hazard_ctrl against a rule-level model.
// Perf counters are checked as well when HAZ_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;
    localparam int MUL = 4;
    localparam int DIV = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] EX_rs, EX_rt, MEM_WriteAddr, WB_WriteAddr, ID_rs, ID_rt, EX_WriteAddr;
    logic       MEM_RegWrite, WB_RegWrite, EX_MemRead, EX_BranchTaken, ID_Jump;
    logic       ID_MDStart, ID_MDDiv, ID_HiLoRead;
    logic [1:0] ForwardA, ForwardB;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_IsDiv, MD_Busy, MD_Done;
`ifdef HAZ_PERF_EN
    logic [31:0] Perf_Stall, Perf_Flush;
`endif

    int          tests = 0, fails = 0;
    int          busy_rem = 0;
    bit          done_m = 0;
    int unsigned ps_m = 0, pf_m = 0;
    logic        g_pcw, g_busy, g_done;
    int          n_busy, n_stall, n_done;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
        .clk(clk), .reset(reset),
        .EX_rs(EX_rs), .EX_rt(EX_rt),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteAddr(MEM_WriteAddr),
        .WB_RegWrite(WB_RegWrite), .WB_WriteAddr(WB_WriteAddr),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .EX_MemRead(EX_MemRead), .EX_WriteAddr(EX_WriteAddr),
        .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
        .ID_MDStart(ID_MDStart), .ID_MDDiv(ID_MDDiv), .ID_HiLoRead(ID_HiLoRead),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MD_Start(MD_Start), .MD_IsDiv(MD_IsDiv),
        .MD_Busy(MD_Busy), .MD_Done(MD_Done)
`ifdef HAZ_PERF_EN
        , .Perf_Stall(Perf_Stall), .Perf_Flush(Perf_Flush)
`endif
    );

    function automatic logic [1:0] ref_fwd(input logic rwm, input logic [4:0] am,
                                           input logic rww, input logic [4:0] aw, input logic [4:0] src);
        if (rwm && am != 0 && am == src) return 2'b10;
        if (rww && aw != 0 && aw == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {EX_rs, EX_rt, MEM_WriteAddr, WB_WriteAddr, ID_rs, ID_rt, EX_WriteAddr} = '0;
        {MEM_RegWrite, WB_RegWrite, EX_MemRead, EX_BranchTaken, ID_Jump} = '0;
        {ID_MDStart, ID_MDDiv, ID_HiLoRead} = '0;
    endtask

    // Compare every output at the negedge, then advance the model on the following posedge.
    task automatic step();
        bit br, st, go;
        bit e_pcw, e_ifw, e_iff, e_idf;
        @(negedge clk);
        br = EX_BranchTaken;
        st = (EX_MemRead && EX_WriteAddr != 0 && (EX_WriteAddr == ID_rs || EX_WriteAddr == ID_rt))
             || (busy_rem > 0 && (ID_MDStart || ID_HiLoRead));
        go = ID_MDStart && !br && !st;
        if (br) {e_pcw, e_ifw, e_iff, e_idf} = 4'b1111;
        else if (st) {e_pcw, e_ifw, e_iff, e_idf} = 4'b0001;
        else if (ID_Jump) {e_pcw, e_ifw, e_iff, e_idf} = 4'b1110;
        else {e_pcw, e_ifw, e_iff, e_idf} = 4'b1100;
        check("fwd_a", ForwardA, ref_fwd(MEM_RegWrite, MEM_WriteAddr, WB_RegWrite, WB_WriteAddr, EX_rs));
        check("fwd_b", ForwardB, ref_fwd(MEM_RegWrite, MEM_WriteAddr, WB_RegWrite, WB_WriteAddr, EX_rt));
        check("pc_write", PC_Write, e_pcw);
        check("ifid_write", IFID_Write, e_ifw);
        check("ifid_flush", IFID_Flush, e_iff);
        check("idex_flush", IDEX_Flush, e_idf);
        check("md_start", MD_Start, go);
        if (go) check("md_isdiv", MD_IsDiv, ID_MDDiv);
        check("md_busy", MD_Busy, busy_rem > 0);
        check("md_done", MD_Done, done_m);
`ifdef HAZ_PERF_EN
        check("perf_stall", Perf_Stall, ps_m);
        check("perf_flush", Perf_Flush, pf_m);
`endif
        g_pcw = PC_Write; g_busy = MD_Busy; g_done = MD_Done;
        @(posedge clk);
        if (!reset) begin
            busy_rem = 0; done_m = 0; ps_m = 0; pf_m = 0;
        end else begin
            if (go) begin
                busy_rem = ID_MDDiv ? DIV : MUL;
                done_m = 0;
            end else if (busy_rem > 0) begin
                busy_rem--;
                done_m = (busy_rem == 0);
            end else done_m = 0;
            ps_m += (st && !br) ? 1 : 0;
            pf_m += (br || ID_Jump) ? 1 : 0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #12;
        check("reset_busy", MD_Busy, 1'b0);
        check("reset_done", MD_Done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        MEM_RegWrite = 1; MEM_WriteAddr = 5; WB_RegWrite = 1; WB_WriteAddr = 5; EX_rs = 5;
        step();
        check("fwd_mem_wins", ForwardA, 2'b10);
        clear_inputs();
        MEM_RegWrite = 1; WB_RegWrite = 1; EX_rt = 0; EX_rs = 7; WB_WriteAddr = 7;
        step();
        clear_inputs();

        EX_MemRead = 1; EX_WriteAddr = 8; ID_rs = 8;
        step();
        check("lu_stall", g_pcw, 1'b0);
        clear_inputs();
        step();
        check("lu_released", g_pcw, 1'b1);

        EX_MemRead = 1; EX_WriteAddr = 8; ID_rt = 8; EX_BranchTaken = 1;
        step();
        clear_inputs();
        ID_Jump = 1;
        step();
        clear_inputs();

        ID_MDStart = 1; ID_MDDiv = 1;
        step();
        clear_inputs();
        ID_HiLoRead = 1;
        n_busy = 0; n_stall = 0; n_done = 0;
        for (int i = 0; i < DIV + 8; i++) begin
            step();
            n_busy += g_busy ? 1 : 0;
            n_stall += g_pcw ? 0 : 1;
            n_done += g_done ? 1 : 0;
        end
        check("div_busy_cycles", n_busy, DIV);
        check("div_stall_cycles", n_stall, DIV);
        check("div_done_pulses", n_done, 1);
        clear_inputs();

        ID_MDStart = 1;
        step();
        clear_inputs();
        step();
        reset = 1'b0;
        #1;
        check("abort_busy", MD_Busy, 1'b0);
        check("abort_done", MD_Done, 1'b0);
        busy_rem = 0; done_m = 0; ps_m = 0; pf_m = 0;
        step();
        reset = 1'b1;
        n_done = 0;
        for (int i = 0; i < MUL + 4; i++) begin
            step();
            n_done += g_done ? 1 : 0;
        end
        check("abort_no_done", n_done, 0);

        for (int i = 0; i < 600; i++) begin
            EX_rs = 5'($urandom_range(0, 3));
            EX_rt = 5'($urandom_range(0, 3));
            MEM_WriteAddr = 5'($urandom_range(0, 3));
            WB_WriteAddr = 5'($urandom_range(0, 3));
            ID_rs = 5'($urandom_range(0, 3));
            ID_rt = 5'($urandom_range(0, 3));
            EX_WriteAddr = 5'($urandom_range(0, 3));
            MEM_RegWrite = 1'($urandom_range(0, 1));
            WB_RegWrite = 1'($urandom_range(0, 1));
            EX_MemRead = ($urandom_range(0, 3) == 0);
            EX_BranchTaken = ($urandom_range(0, 7) == 0);
            ID_Jump = ($urandom_range(0, 7) == 0);
            ID_MDStart = ($urandom_range(0, 5) == 0);
            ID_MDDiv = 1'($urandom_range(0, 1));
            ID_HiLoRead = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
